// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shifter: shift-mode codes and FSM states.
package shift_pkg;

   localparam logic [1:0] OP_LSL = 2'b00;
   localparam logic [1:0] OP_LSR = 2'b01;
   localparam logic [1:0] OP_ASR = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/shift_step.sv
// Single-bit shift of r in the mode selected by op. Purely combinational.
module shift_step
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] r,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] shifted
);

   // One step of LSL / LSR / ASR / ROR
   always_comb begin
      shifted = r;
      unique case (op)
         OP_LSL: shifted = {r[WIDTH-2:0], 1'b0};
         OP_LSR: shifted = {1'b0, r[WIDTH-1:1]};
         OP_ASR: shifted = {r[WIDTH-1], r[WIDTH-1:1]};
         OP_ROR: shifted = {r[0], r[WIDTH-1:1]};
      endcase
   end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: accepts an operand, shifts one bit per clock, then
// holds the result until the consumer takes it.
module seq_shifter
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [1:0]         op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   y,
   output logic               busy
);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   r_q, r_d, step;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;

   shift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .r       (r_q),
      .op      (op_q),
      .shifted (step)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: a zero shift skips straight to DONE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = (shamt == '0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cnt_q == SHAMT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath next-state: latch request in IDLE, step and count down in SHIFT
   always_comb begin
      r_d   = r_q;
      cnt_d = cnt_q;
      op_d  = op_q;
      if (state_q == ST_IDLE && in_valid) begin
         r_d   = a;
         cnt_d = shamt;
         op_d  = op;
      end else if (state_q == ST_SHIFT) begin
         r_d   = step;
         cnt_d = cnt_q - SHAMT_W'(1);
      end
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q   <= '0;
         cnt_q <= '0;
         op_q  <= OP_LSL;
      end else begin
         r_q   <= r_d;
         cnt_q <= cnt_d;
         op_q  <= op_d;
      end
   end

   // Handshake and status outputs decode from state only
   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      busy      = (state_q != ST_IDLE);
   end

   assign y = r_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: an 8-bit instance checked every cycle against a
// transaction-level model, plus a 4-bit instance for the legacy ASR sweep.
module tb_seq_shifter;

   localparam logic [1:0] LSL = 2'b00;
   localparam logic [1:0] LSR = 2'b01;
   localparam logic [1:0] ASR = 2'b10;
   localparam logic [1:0] ROR = 2'b11;

   logic       clk;
   logic       rst;
   logic       in_valid, in_ready, out_valid, out_ready, busy;
   logic [7:0] a, y;
   logic [2:0] shamt;
   logic [1:0] op;

   logic       rst4;
   logic       in_valid4, in_ready4, out_valid4, out_ready4, busy4;
   logic [3:0] a4, y4;
   logic [1:0] shamt4;
   logic [1:0] op4;

   int n_checks = 0;
   int n_fail   = 0;

   seq_shifter #(
      .WIDTH (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .shamt     (shamt),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .busy      (busy)
   );

   seq_shifter #(
      .WIDTH (4)
   ) dut4 (
      .clk       (clk),
      .rst       (rst4),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .a         (a4),
      .shamt     (shamt4),
      .op        (op4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .y         (y4),
      .busy      (busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Whole-operation result from the mode definitions
   function automatic logic [7:0] ref_shift(input logic [7:0] v, input int n,
                                            input logic [1:0] o);
      logic [15:0]       dbl;
      logic signed [7:0] s;
      case (o)
         2'b00:   return v << n;
         2'b01:   return v >> n;
         2'b10: begin
            s = v;
            return 8'(s >>> n);
         end
         default: begin
            dbl = {v, v} >> n;
            return dbl[7:0];
         end
      endcase
   endfunction

   // Transaction model: one request in flight, result valid n cycles after acceptance
   bit         m_pend = 1'b0;
   int         m_cyc  = 0;
   int         m_e0   = 0;
   int         m_n    = 0;
   logic [7:0] m_y    = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pend = 1'b0;
         m_cyc  = 0;
      end else begin
         bit v;
         v = m_pend && (m_cyc >= m_e0 + m_n);
         if (!m_pend) begin
            if (in_valid) begin
               m_pend = 1'b1;
               m_e0   = m_cyc + 1;
               m_n    = int'(shamt);
               m_y    = ref_shift(a, int'(shamt), op);
            end
         end else if (v && out_ready) begin
            m_pend = 1'b0;
         end
         m_cyc++;
      end
   end

   // Per-cycle comparison of the 8-bit instance against the model
   always @(negedge clk) begin
      if (!rst) begin
         bit mv;
         mv = m_pend && (m_cyc >= m_e0 + m_n);
         chk("in_ready", 32'(in_ready), 32'(!m_pend));
         chk("busy", 32'(busy), 32'(m_pend));
         chk("out_valid", 32'(out_valid), 32'(mv));
         if (mv) chk("y", 32'(y), 32'(m_y));
      end
   end

   task automatic req8(input logic [7:0] av, input logic [2:0] sv, input logic [1:0] ov,
                       input logic [7:0] exp_y, input string nm);
      int lat;
      @(negedge clk);
      in_valid = 1'b1;
      a        = av;
      shamt    = sv;
      op       = ov;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a        = 8'($urandom);
      shamt    = 3'($urandom);
      op       = 2'($urandom);
      if (sv != 3'd0) chk({nm, " busy"}, 32'(busy), 32'd1);
      lat = 0;
      while (!out_valid && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, " latency"}, 32'(lat), 32'(sv));
      chk({nm, " y"}, 32'(y), 32'(exp_y));
   endtask

   task automatic req4(input logic [3:0] av, input logic [3:0] exp_y, input string nm);
      int lat;
      @(negedge clk);
      in_valid4 = 1'b1;
      a4        = av;
      shamt4    = 2'd1;
      op4       = ASR;
      @(posedge clk);
      @(negedge clk);
      in_valid4 = 1'b0;
      lat = 0;
      while (!out_valid4 && lat < 16) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, " latency"}, 32'(lat), 32'd1);
      chk({nm, " y"}, 32'(y4), 32'(exp_y));
   endtask

   initial begin
      int waited;
      logic [3:0] sweep_a [6] = '{4'b0000, 4'b0001, 4'b0111, 4'b1000, 4'b1011, 4'b1111};
      logic [3:0] sweep_y [6] = '{4'b0000, 4'b0000, 4'b0011, 4'b1100, 4'b1101, 4'b1111};

      rst = 1'b1; rst4 = 1'b1;
      in_valid = 1'b0; a = '0; shamt = '0; op = LSL; out_ready = 1'b1;
      in_valid4 = 1'b0; a4 = '0; shamt4 = '0; op4 = LSL; out_ready4 = 1'b1;
      #2;
      chk("reset y", 32'(y), 32'd0);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset4 in_ready", 32'(in_ready4), 32'd1);
      @(negedge clk);
      rst = 1'b0; rst4 = 1'b0;

      req8(8'h80, 3'd3, ASR, 8'hF0, "asr80by3");
      req8(8'hA5, 3'd0, LSL, 8'hA5, "lslA5by0");
      req8(8'h81, 3'd1, ROR, 8'hC0, "ror81by1");
      req8(8'hF0, 3'd7, LSR, 8'h01, "lsrF0by7");
      req8(8'h01, 3'd7, LSL, 8'h80, "lsl01by7");

      // Backpressure: result held, new requests ignored
      @(negedge clk);
      in_valid = 1'b1; a = 8'h3C; shamt = 3'd2; op = LSR;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      waited = 0;
      while (!out_valid && waited < 16) begin
         @(negedge clk);
         waited++;
      end
      chk("bp reached done", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("bp y", 32'(y), 32'h0F);
         chk("bp out_valid", 32'(out_valid), 32'd1);
         chk("bp in_ready", 32'(in_ready), 32'd0);
         in_valid = 1'(i % 2 == 0);
         a = 8'($urandom); shamt = 3'($urandom); op = 2'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("bp idle in_ready", 32'(in_ready), 32'd1);
      chk("bp idle out_valid", 32'(out_valid), 32'd0);

      // Reset between clock edges during an ASR by 5
      in_valid = 1'b1; a = 8'h80; shamt = 3'd5; op = ASR;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst y", 32'(y), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      #2 rst = 1'b0;
      req8(8'h96, 3'd4, LSR, 8'h09, "post-reset lsr");

      // Random traffic with random backpressure, checked by the model
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         in_valid  = 1'($urandom_range(0, 1));
         a         = 8'($urandom);
         shamt     = 3'($urandom);
         op        = 2'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      waited = 0;
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk("drain idle", 32'(in_ready), 32'd1);

      // Legacy 4-bit arithmetic-right-by-1 regression
      for (int i = 0; i < 6; i++) begin
         req4(sweep_a[i], sweep_y[i], $sformatf("w4 asr %b", sweep_a[i]));
      end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
